// File: rtl/wb_stage_pkg.sv
// Shared definitions for the LemonPC writeback stage: widths and source identifiers.
package wb_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic {
    WB_SRC_EXU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_stage_arbiter.sv
// Two-way round-robin arbiter (bit 0 = EXU, bit 1 = LSU).
// The grant is combinational; only the last winner is stored.
module wb_arbiter
  import wb_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       xfer,
  output logic [1:0] gnt
);

  wb_src_e rr_last;

  always_comb begin
    // NOTE: default every output first so no path through the block infers a latch.
    gnt = req;
    if (req == 2'b11) begin
      gnt = (rr_last == WB_SRC_EXU) ? 2'b10 : 2'b01;
    end
  end

  // Reset to LSU so EXU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      rr_last <= WB_SRC_LSU;
    end else if (xfer) begin
      rr_last <= gnt[1] ? WB_SRC_LSU : WB_SRC_EXU;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// LemonPC writeback stage: arbitrates EXU/LSU results onto the register-file write port.
// Optional forwarding outputs are enabled by defining WB_BYPASS_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data,
  output logic                  byp_valid,
  output logic [ADDR_WIDTH-1:0] byp_rd,
  output logic [DATA_WIDTH-1:0] byp_data,
  output logic [63:0]           instret
);

  logic [1:0]            gnt;
  logic                  xfer;
  logic                  sel_wen;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  wb_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({lsu_valid, exu_valid}),
    .xfer  (xfer),
    .gnt   (gnt)
  );

  assign exu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign xfer      = |gnt;

  assign sel_wen  = gnt[1] ? lsu_wen  : exu_wen;
  assign sel_rd   = gnt[1] ? lsu_rd   : exu_rd;
  assign sel_data = gnt[1] ? lsu_data : exu_data;

  // x0 is hardwired zero: such beats retire but never assert the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen  <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
      instret <= '0;
    end else if (xfer) begin
      rf_wen  <= sel_wen && (sel_rd != '0);
      rf_rd   <= sel_rd;
      rf_data <= sel_data;
      instret <= instret + 64'd1;
    end else begin
      rf_wen  <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid = rf_wen;
  assign byp_rd    = rf_rd;
  assign byp_data  = rf_data;
`else
  assign byp_valid = 1'b0;
  assign byp_rd    = '0;
  assign byp_data  = '0;
`endif

endmodule
